// File: rtl/corevx_writeback_if.sv
// corevx_writeback_if: bundles the dispatch-issue, ALU result, LSU result,
// register-file write port and scoreboard signals of the writeback block.
//   master : producer side (dispatch, ALU, LSU); drives valids/payloads and
//            issue info, observes readies, hazard, write port and pending.
//   slave  : the writeback block itself.
interface corevx_writeback_if;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_hazard;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        rd_write;
  logic [31:0] pending;

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
           alu_valid, alu_rd, alu_wdata, lsu_valid, lsu_rd, lsu_wdata,
    input  issue_hazard, alu_ready, lsu_ready, rd_addr, rd_wdata, rd_write, pending
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
           alu_valid, alu_rd, alu_wdata, lsu_valid, lsu_rd, lsu_wdata,
    output issue_hazard, alu_ready, lsu_ready, rd_addr, rd_wdata, rd_write, pending
  );
endinterface

// File: rtl/corevx_writeback.sv
// corevx_writeback: merges ALU results (buffered in a small FIFO) and LSU
// results (unbuffered) onto the single register-file write port, and keeps a
// pending-write scoreboard that dispatch uses to stall on RAW/WAW hazards.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - corevx_writeback_if.slave: issue/hazard, ALU and LSU result
//          handshakes, registered rd_addr/rd_wdata/rd_write, pending bitmap
module corevx_writeback #(
  parameter int ALU_FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  corevx_writeback_if.slave bus
);
  localparam int PW = $clog2(ALU_FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(ALU_FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_t;

  wb_t           mem [ALU_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_full, fifo_empty;
  logic          push, pop, lsu_take, win_valid;
  wb_t           win;
  logic [31:0]   pending_q, pending_d;

  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);

  // Readies look only at registered occupancy, so a same-cycle pop never
  // opens a slot for a push.
  assign bus.alu_ready = !fifo_full && !rst;
  assign bus.lsu_ready = !fifo_full && !rst;

  assign push     = bus.alu_valid && bus.alu_ready;
  assign lsu_take = bus.lsu_valid && bus.lsu_ready;
  // A full FIFO always drains (LSU is blocked by its ready); otherwise the
  // FIFO only gets the port when the LSU is idle.
  assign pop       = !fifo_empty && (fifo_full || !bus.lsu_valid);
  assign win_valid = lsu_take || pop;

  always_comb begin
    win = mem[rd_ptr];
    if (lsu_take) win = '{rd: bus.lsu_rd, wdata: bus.lsu_wdata};
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: bus.alu_rd, wdata: bus.alu_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Write port register; rd=0 winners are consumed without a write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_write <= 1'b0;
      bus.rd_addr  <= '0;
      bus.rd_wdata <= '0;
    end else begin
      bus.rd_write <= win_valid && (win.rd != '0);
      if (win_valid) begin
        bus.rd_addr  <= win.rd;
        bus.rd_wdata <= win.wdata;
      end
    end
  end

  // Scoreboard: no bypass, so the bit clears only after the write cycle.
  assign bus.issue_hazard = bus.issue_valid &&
    (pending_q[bus.issue_rs1] || pending_q[bus.issue_rs2] || pending_q[bus.issue_rd]);

  always_comb begin
    pending_d = pending_q;
    if (bus.rd_write) pending_d[bus.rd_addr] = 1'b0;
    if (bus.issue_valid && !bus.issue_hazard && bus.issue_rd != '0)
      pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign bus.pending = pending_q;
endmodule

// File: tb/tb_corevx_writeback.sv
// Bench for corevx_writeback: directed scenarios plus randomized traffic,
// checked against a queue-based model of the writeback rules.
module tb_corevx_writeback;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  corevx_writeback_if bus();
  corevx_writeback #(.ALU_FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_fail = 0;

  // Reference model state
  logic [36:0] wb_q[$];
  logic [31:0] m_pending = '0;
  logic        m_wr = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_alu_acc = 0, m_lsu_acc = 0;

  // Advance one clock, evolving the model from the inputs seen at the edge.
  task automatic step();
    bit full, hz, win;
    logic [36:0] w;
    logic [31:0] np;
    full = (wb_q.size() == DEPTH);
    hz = bus.issue_valid && (m_pending[bus.issue_rs1] || m_pending[bus.issue_rs2] ||
                             m_pending[bus.issue_rd]);
    m_alu_acc = !rst && !full && bus.alu_valid;
    m_lsu_acc = !rst && !full && bus.lsu_valid;
    np = m_pending;
    if (m_wr) np[m_addr] = 1'b0;
    if (bus.issue_valid && !hz && bus.issue_rd != 0) np[bus.issue_rd] = 1'b1;
    np[0] = 1'b0;
    win = 0; w = '0;
    if (full) begin w = wb_q.pop_front(); win = 1; end
    else if (m_lsu_acc) begin w = {bus.lsu_rd, bus.lsu_wdata}; win = 1; end
    else if (wb_q.size() > 0) begin w = wb_q.pop_front(); win = 1; end
    if (m_alu_acc) wb_q.push_back({bus.alu_rd, bus.alu_wdata});
    @(posedge clk);
    if (rst) begin
      wb_q.delete(); m_pending = '0; m_wr = 0; m_addr = '0; m_data = '0;
      m_alu_acc = 0; m_lsu_acc = 0;
    end else begin
      m_pending = np;
      m_wr = win && (w[36:32] != 0);
      if (m_wr) begin m_addr = w[36:32]; m_data = w[31:0]; end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_wdata = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd3; bus.lsu_wdata = 32'h1234;
    bus.issue_valid = 1; bus.issue_rd = 5'd3;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready: got %b want 0", bus.alu_ready); end
    n_cmp++; if (bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_ready: got %b want 0", bus.lsu_ready); end
    step(); step();
    n_cmp++; if (bus.rd_write !== 1'b0) begin n_fail++; $display("FAIL rst_rd_write: got %b want 0", bus.rd_write); end
    n_cmp++; if (bus.rd_addr !== 5'd0) begin n_fail++; $display("FAIL rst_rd_addr: got %0d want 0", bus.rd_addr); end
    n_cmp++; if (bus.rd_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_rd_wdata: got %h want 0", bus.rd_wdata); end
    n_cmp++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL rst_pending: got %h want 0", bus.pending); end
    idle_inputs();
    rst = 0; #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_alu_ready: got %b want 1", bus.alu_ready); end
    n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_lsu_ready: got %b want 1", bus.lsu_ready); end
    step();
    n_cmp++; if (bus.rd_write !== 1'b0) begin n_fail++; $display("FAIL idle_rd_write: got %b want 0", bus.rd_write); end
    n_cmp++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL idle_pending: got %h want 0", bus.pending); end
  endtask

  task automatic test_alu_chain();
    bus.issue_valid = 1; bus.issue_rd = 5'd5; #1;
    n_cmp++; if (bus.issue_hazard !== 1'b0) begin n_fail++; $display("FAIL chain_issue_hz: got %b want 0", bus.issue_hazard); end
    step();
    bus.issue_valid = 0; bus.issue_rd = '0;
    n_cmp++; if (bus.pending !== 32'h20) begin n_fail++; $display("FAIL chain_pending_set: got %h want 20", bus.pending); end
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_wdata = 32'hDEADBEEF; #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL chain_alu_ready: got %b want 1", bus.alu_ready); end
    step();
    bus.alu_valid = 0;
    bus.issue_valid = 1; bus.issue_rs1 = 5'd5; #1;
    n_cmp++; if (bus.rd_write !== 1'b0) begin n_fail++; $display("FAIL chain_early_wr: got %b want 0", bus.rd_write); end
    n_cmp++; if (bus.issue_hazard !== 1'b1) begin n_fail++; $display("FAIL chain_raw_hz1: got %b want 1", bus.issue_hazard); end
    step();
    n_cmp++; if (bus.rd_write !== 1'b1) begin n_fail++; $display("FAIL chain_wr: got %b want 1", bus.rd_write); end
    n_cmp++; if (bus.rd_addr !== 5'd5) begin n_fail++; $display("FAIL chain_addr: got %0d want 5", bus.rd_addr); end
    n_cmp++; if (bus.rd_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL chain_data: got %h want deadbeef", bus.rd_wdata); end
    n_cmp++; if (bus.pending !== 32'h20) begin n_fail++; $display("FAIL chain_pending_wcyc: got %h want 20", bus.pending); end
    n_cmp++; if (bus.issue_hazard !== 1'b1) begin n_fail++; $display("FAIL chain_raw_hz_wcyc: got %b want 1", bus.issue_hazard); end
    step();
    n_cmp++; if (bus.rd_write !== 1'b0) begin n_fail++; $display("FAIL chain_after_wr: got %b want 0", bus.rd_write); end
    n_cmp++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL chain_pending_clr: got %h want 0", bus.pending); end
    n_cmp++; if (bus.issue_hazard !== 1'b0) begin n_fail++; $display("FAIL chain_raw_hz_gone: got %b want 0", bus.issue_hazard); end
    idle_inputs();
  endtask

  task automatic test_contention();
    int wr_cnt = 0, acc_cnt = 0;
    bus.alu_valid = 1; bus.lsu_valid = 1;
    bus.alu_rd = 5'd20; bus.alu_wdata = 32'hA000_0000;
    bus.lsu_rd = 5'd10; bus.lsu_wdata = 32'hB000_0000; #1;
    n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL cont_lsu_ready0: got %b want 1", bus.lsu_ready); end
    step(); wr_cnt += int'(bus.rd_write); acc_cnt += int'(m_alu_acc) + int'(m_lsu_acc);
    n_cmp++; if (bus.rd_addr !== 5'd10 || bus.rd_write !== 1'b1) begin n_fail++; $display("FAIL cont_lsu_win0: got %0d/%b want 10/1", bus.rd_addr, bus.rd_write); end
    bus.alu_rd = 5'd21; bus.alu_wdata = 32'hA000_0001;
    bus.lsu_rd = 5'd11; bus.lsu_wdata = 32'hB000_0001;
    step(); wr_cnt += int'(bus.rd_write); acc_cnt += int'(m_alu_acc) + int'(m_lsu_acc);
    n_cmp++; if (bus.rd_wdata !== 32'hB000_0001) begin n_fail++; $display("FAIL cont_lsu_win1: got %h want b0000001", bus.rd_wdata); end
    bus.alu_rd = 5'd22; bus.alu_wdata = 32'hA000_0002;
    bus.lsu_rd = 5'd12; bus.lsu_wdata = 32'hB000_0002; #1;
    n_cmp++; if (bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL cont_lsu_blocked: got %b want 0", bus.lsu_ready); end
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL cont_alu_blocked: got %b want 0", bus.alu_ready); end
    step(); wr_cnt += int'(bus.rd_write); acc_cnt += int'(m_alu_acc) + int'(m_lsu_acc);
    n_cmp++; if (bus.rd_addr !== 5'd20 || bus.rd_wdata !== 32'hA000_0000) begin n_fail++; $display("FAIL cont_head_win: got %0d/%h want 20/a0000000", bus.rd_addr, bus.rd_wdata); end
    for (int i = 0; i < 10; i++) begin
      if (i == 7) begin bus.alu_valid = 0; bus.lsu_valid = 0; end
      else if (m_alu_acc) begin
        bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_wdata = $urandom;
        bus.lsu_rd = 5'($urandom_range(1, 31)); bus.lsu_wdata = $urandom;
      end
      step(); wr_cnt += int'(bus.rd_write); acc_cnt += int'(m_alu_acc) + int'(m_lsu_acc);
      n_cmp++; if (bus.rd_write !== m_wr || (m_wr && (bus.rd_addr !== m_addr || bus.rd_wdata !== m_data)))
        begin n_fail++; $display("FAIL cont_model c%0d: got %b/%0d/%h want %b/%0d/%h", i, bus.rd_write, bus.rd_addr, bus.rd_wdata, m_wr, m_addr, m_data); end
    end
    n_cmp++; if (wr_cnt != acc_cnt) begin n_fail++; $display("FAIL cont_no_loss: got %0d writes want %0d", wr_cnt, acc_cnt); end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    bus.alu_valid = 1; bus.alu_rd = '0; bus.alu_wdata = 32'h1111;
    bus.lsu_valid = 1; bus.lsu_rd = '0; bus.lsu_wdata = 32'h2222;
    step();
    bus.alu_valid = 0; bus.lsu_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.rd_write !== 1'b0) begin n_fail++; $display("FAIL rd0_wr c%0d: got %b want 0", i, bus.rd_write); end
      step();
    end
    bus.issue_valid = 1; bus.issue_rd = '0;
    step();
    bus.issue_valid = 0;
    n_cmp++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL rd0_pending: got %h want 0", bus.pending); end
    idle_inputs();
  endtask

  task automatic test_waw();
    bus.issue_valid = 1; bus.issue_rd = 5'd7; #1;
    n_cmp++; if (bus.issue_hazard !== 1'b0) begin n_fail++; $display("FAIL waw_first_hz: got %b want 0", bus.issue_hazard); end
    step();
    n_cmp++; if (bus.issue_hazard !== 1'b1) begin n_fail++; $display("FAIL waw_second_hz: got %b want 1", bus.issue_hazard); end
    step();
    n_cmp++; if (bus.pending !== 32'h80 || bus.issue_hazard !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %h/%b want 80/1", bus.pending, bus.issue_hazard); end
    bus.lsu_valid = 1; bus.lsu_rd = 5'd7; bus.lsu_wdata = 32'h7777;
    step();
    bus.lsu_valid = 0;
    n_cmp++; if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd7) begin n_fail++; $display("FAIL waw_wb: got %b/%0d want 1/7", bus.rd_write, bus.rd_addr); end
    n_cmp++; if (bus.issue_hazard !== 1'b1) begin n_fail++; $display("FAIL waw_hz_wcyc: got %b want 1", bus.issue_hazard); end
    step();
    n_cmp++; if (bus.issue_hazard !== 1'b0 || bus.pending !== 32'h0) begin n_fail++; $display("FAIL waw_release: got %b/%h want 0/0", bus.issue_hazard, bus.pending); end
    step();
    bus.issue_valid = 0;
    n_cmp++; if (bus.pending !== 32'h80) begin n_fail++; $display("FAIL waw_second_set: got %h want 80", bus.pending); end
    bus.lsu_valid = 1; step(); bus.lsu_valid = 0; step();
    n_cmp++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL waw_cleanup: got %h want 0", bus.pending); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.issue_valid = 1; bus.issue_rd = 5'd5; step();
    bus.issue_rd = 5'd7; step();
    bus.issue_valid = 0; bus.issue_rd = '0;
    bus.alu_valid = 1; bus.alu_rd = 5'd12; bus.alu_wdata = 32'hC0;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd9; bus.lsu_wdata = 32'h90;
    step();
    bus.alu_rd = 5'd13; bus.alu_wdata = 32'hC1; bus.lsu_wdata = 32'h91;
    step();
    n_cmp++; if (bus.pending !== 32'hA0) begin n_fail++; $display("FAIL mid_pending_pre: got %h want a0", bus.pending); end
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_fifo_full: got %b want 0", bus.alu_ready); end
    idle_inputs();
    rst = 1; step(); rst = 0;
    n_cmp++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL mid_pending_clr: got %h want 0", bus.pending); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (bus.rd_write !== 1'b0) begin n_fail++; $display("FAIL mid_no_write c%0d: got %b want 0", i, bus.rd_write); end
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 127) == 0);
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd  = 5'($urandom_range(0, 7));
      bus.issue_rs1 = 5'($urandom_range(0, 7));
      bus.issue_rs2 = 5'($urandom_range(0, 7));
      if (!bus.alu_valid || m_alu_acc) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd = 5'($urandom_range(0, 7)); bus.alu_wdata = $urandom;
      end
      if (!bus.lsu_valid || m_lsu_acc) begin
        bus.lsu_valid = ($urandom_range(0, 2) == 0);
        bus.lsu_rd = 5'($urandom_range(0, 7)); bus.lsu_wdata = $urandom;
      end
      #1;
      n_cmp++; if (bus.alu_ready !== (!rst && wb_q.size() < DEPTH) || bus.lsu_ready !== (!rst && wb_q.size() < DEPTH))
        begin n_fail++; $display("FAIL rnd_ready c%0d: got %b/%b want %b", c, bus.alu_ready, bus.lsu_ready, !rst && wb_q.size() < DEPTH); end
      n_cmp++; if (bus.issue_hazard !== (bus.issue_valid && (m_pending[bus.issue_rs1] || m_pending[bus.issue_rs2] || m_pending[bus.issue_rd])))
        begin n_fail++; $display("FAIL rnd_hazard c%0d: got %b", c, bus.issue_hazard); end
      step();
      n_cmp++; if (bus.rd_write !== m_wr || (m_wr && (bus.rd_addr !== m_addr || bus.rd_wdata !== m_data)))
        begin n_fail++; $display("FAIL rnd_wb c%0d: got %b/%0d/%h want %b/%0d/%h", c, bus.rd_write, bus.rd_addr, bus.rd_wdata, m_wr, m_addr, m_data); end
      n_cmp++; if (bus.pending !== m_pending) begin n_fail++; $display("FAIL rnd_pending c%0d: got %h want %h", c, bus.pending, m_pending); end
    end
    rst = 0;
    idle_inputs();
    step(); step(); step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_chain();
    test_contention();
    test_rd_zero();
    test_waw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
